// File: rtl/fir_channel_scheduler.sv
// fir_channel_scheduler: round-robin arbiter that shares one FIR core between
// four sample channels. A winning channel's sample is latched and handed to
// the core, and the core's result is presented downstream with the channel
// index attached.
// Optional build macro FIR_SCHED_TIMEOUT_EN: when defined, a WAIT that lasts
// TIMEOUT cycles with no core_done is aborted and an error result is emitted.
// When it is not defined, WAIT never times out and out_err is tied low.
//
// state | meaning
// IDLE  | no transaction; arbitrate among req_valid
// ISSUE | sample latched; pulse core_start
// WAIT  | waiting for core_done (or timeout)
// OUT   | result presented; hold until out_ready
module fir_channel_scheduler #(
    parameter int NUM_CH  = 4,
    parameter int DW      = 32,
    parameter int TIMEOUT = 63
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NUM_CH-1:0]    req_valid,
    input  logic [NUM_CH*DW-1:0] req_data,
    output logic [NUM_CH-1:0]    req_ready,
    output logic                 core_start,
    output logic [DW-1:0]        core_x,
    input  logic                 core_done,
    input  logic [DW-1:0]        core_y,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [DW-1:0]        out_data,
    output logic [1:0]           out_chan,
    output logic                 out_err,
    output logic                 busy
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_ISSUE = 2'd1;
    localparam logic [1:0] S_WAIT  = 2'd2;
    localparam logic [1:0] S_OUT   = 2'd3;

    localparam int TW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);

    logic [1:0]    state;
    logic [1:0]    last_grant;
    logic [1:0]    gnt_idx;
    logic [1:0]    next_idx;
    logic [1:0]    cand;
    logic          any_req;
    logic          grant;
    logic [TW-1:0] wait_cnt;
`ifdef FIR_SCHED_TIMEOUT_EN
    logic          err_q;
`endif

    // Round-robin pick: scan offsets 4..1 from last_grant so the smallest
    // offset with a valid request is the one that sticks.
    always_comb begin
        any_req  = 1'b0;
        next_idx = last_grant;
        cand     = last_grant;
        for (int i = NUM_CH; i >= 1; i--) begin
            cand = last_grant + 2'(i);
            if (req_valid[cand]) begin
                any_req  = 1'b1;
                next_idx = cand;
            end
        end
    end

    // Handshake and status outputs are decoded from state; reset masks them
    // so nothing leaks out during the reset cycle itself.
    always_comb begin
        grant      = (state == S_IDLE) && any_req && !rst;
        req_ready  = grant ? (NUM_CH'(1) << next_idx) : '0;
        core_start = (state == S_ISSUE) && !rst;
        out_valid  = (state == S_OUT) && !rst;
        busy       = (state != S_IDLE) && !rst;
        out_chan   = gnt_idx;
    end

`ifdef FIR_SCHED_TIMEOUT_EN
    assign out_err = err_q;
`else
    assign out_err = 1'b0;
`endif

    // Main sequencer: grant, start the core, collect its result, hand it off.
    // The WAIT down-counter is always kept; only the timeout build acts on it.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= S_IDLE;
            last_grant <= 2'd3;
            gnt_idx    <= 2'd0;
            core_x     <= '0;
            out_data   <= '0;
            wait_cnt   <= '0;
`ifdef FIR_SCHED_TIMEOUT_EN
            err_q      <= 1'b0;
`endif
        end else begin
            case (state)
                S_IDLE: begin
                    if (any_req) begin
                        last_grant <= next_idx;
                        gnt_idx    <= next_idx;
                        core_x     <= req_data[int'(next_idx)*DW +: DW];
                        state      <= S_ISSUE;
                    end
                end
                S_ISSUE: begin
                    wait_cnt <= TW'(TIMEOUT - 1);
`ifdef FIR_SCHED_TIMEOUT_EN
                    err_q    <= 1'b0;
`endif
                    state    <= S_WAIT;
                end
                S_WAIT: begin
                    if (core_done) begin
                        out_data <= core_y;
                        state    <= S_OUT;
                    end
`ifdef FIR_SCHED_TIMEOUT_EN
                    else if (wait_cnt == '0) begin
                        out_data <= '0;
                        err_q    <= 1'b1;
                        state    <= S_OUT;
                    end
`endif
                    else begin
                        wait_cnt <= wait_cnt - 1'b1;
                    end
                end
                default: begin
                    if (out_ready) begin
                        state <= S_IDLE;
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fir_channel_scheduler.sv
// Self-checking bench for fir_channel_scheduler: directed scenarios plus a
// randomized run, all compared against a channel-level round-robin model.
module tb_fir_channel_scheduler;

    localparam int NCH = 4;
    localparam int W   = 32;
    localparam int TO  = 63;

    logic             clk = 1'b0;
    logic             rst;
    logic [NCH-1:0]   req_valid;
    logic [NCH*W-1:0] req_data;
    logic [NCH-1:0]   req_ready;
    logic             core_start;
    logic [W-1:0]     core_x;
    logic             core_done;
    logic [W-1:0]     core_y;
    logic             out_valid;
    logic             out_ready;
    logic [W-1:0]     out_data;
    logic [1:0]       out_chan;
    logic             out_err;
    logic             busy;

    int checks   = 0;
    int failures = 0;
    int model_last;

    fir_channel_scheduler #(.NUM_CH(NCH), .DW(W), .TIMEOUT(TO)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_data(req_data), .req_ready(req_ready),
        .core_start(core_start), .core_x(core_x),
        .core_done(core_done), .core_y(core_y),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_data(out_data), .out_chan(out_chan), .out_err(out_err),
        .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Reference arbiter: first requesting channel after the last one granted.
    function automatic int model_grant(input logic [3:0] mask);
        for (int off = 1; off <= 4; off++) begin
            if (mask[(model_last + off) % 4]) return (model_last + off) % 4;
        end
        return -1;
    endfunction

    // Present requests, check the grant cycle and the core_start cycle.
    task automatic start_txn(input logic [3:0] mask, output int g);
        logic [31:0] x;
        g = model_grant(mask);
        @(posedge clk); #1;
        req_valid = mask;
        for (int c = 0; c < NCH; c++) req_data[c*W +: W] = $urandom;
        x = req_data[g*W +: W];
        model_last = g;
        @(negedge clk);
        chk("grant_ready", {28'd0, req_ready}, 32'd1 << g);
        chk("grant_busy", {31'd0, busy}, 32'd0);
        chk("grant_nostart", {31'd0, core_start}, 32'd0);
        @(posedge clk); #1;
        out_ready = 1'b0;
        chk("issue_start", {31'd0, core_start}, 32'd1);
        chk("issue_x", core_x, x);
        chk("issue_ready", {28'd0, req_ready}, 32'd0);
        chk("issue_busy", {31'd0, busy}, 32'd1);
    endtask

    // Full transaction: core answers lat cycles after start, downstream stalls.
    task automatic txn(input logic [3:0] mask, input int lat, input int stall, input logic [31:0] y);
        int g;
        start_txn(mask, g);
        for (int i = 1; i < lat; i++) begin
            @(posedge clk); #1;
            chk("wait_nostart", {31'd0, core_start}, 32'd0);
            chk("wait_novalid", {31'd0, out_valid}, 32'd0);
        end
        @(posedge clk); #1;
        core_done = 1'b1;
        core_y = y;
        @(posedge clk); #1;
        core_done = 1'b0;
        core_y = $urandom;
        chk("out_valid", {31'd0, out_valid}, 32'd1);
        chk("out_data", out_data, y);
        chk("out_chan", {30'd0, out_chan}, g);
        chk("out_err", {31'd0, out_err}, 32'd0);
        for (int i = 0; i < stall; i++) begin
            @(posedge clk); #1;
            chk("stall_valid", {31'd0, out_valid}, 32'd1);
            chk("stall_data", out_data, y);
            chk("stall_chan", {30'd0, out_chan}, g);
            chk("stall_ready", {28'd0, req_ready}, 32'd0);
            chk("stall_busy", {31'd0, busy}, 32'd1);
        end
        out_ready = 1'b1;
        @(negedge clk);
        chk("hs_valid", {31'd0, out_valid}, 32'd1);
        @(posedge clk); #1;
        out_ready = 1'b0;
        req_valid = '0;
        chk("idle_busy", {31'd0, busy}, 32'd0);
        chk("idle_valid", {31'd0, out_valid}, 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int g;
        int n;
        rst = 1'b1;
        req_valid = 4'hF;
        req_data = '0;
        core_done = 1'b0;
        core_y = '0;
        out_ready = 1'b0;
        model_last = 3;

        // Reset state, with requests present that must not be granted
        @(posedge clk); @(posedge clk); #1;
        chk("rst_ready", {28'd0, req_ready}, 32'd0);
        chk("rst_start", {31'd0, core_start}, 32'd0);
        chk("rst_x", core_x, 32'd0);
        chk("rst_valid", {31'd0, out_valid}, 32'd0);
        chk("rst_data", out_data, 32'd0);
        chk("rst_chan", {30'd0, out_chan}, 32'd0);
        chk("rst_err", {31'd0, out_err}, 32'd0);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        req_valid = '0;
        rst = 1'b0;

        // Only ch2 requesting, core answers 0xA three cycles after start
        txn(4'b0100, 3, 0, 32'h0000_000A);

        // All channels requesting: six rounds in rotation
        for (int i = 0; i < 6; i++) txn(4'b1111, 1, 0, $urandom);

        // Downstream stall of five cycles
        txn(4'b1111, 2, 5, 32'hDEAD_BEEF);

        // Single requester re-granted each round
        for (int i = 0; i < 3; i++) txn(4'b1000, 1, 0, $urandom);

        // core_done while idle with no requests is ignored
        @(posedge clk); #1;
        core_done = 1'b1;
        core_y = 32'h1234_5678;
        @(posedge clk); #1;
        core_done = 1'b0;
        chk("stray_valid", {31'd0, out_valid}, 32'd0);
        chk("stray_busy", {31'd0, busy}, 32'd0);
        @(posedge clk); #1;
        chk("stray_valid2", {31'd0, out_valid}, 32'd0);

        // Reset in WAIT abandons the transaction; priority returns to ch0
        start_txn(4'b0110, g);
        @(posedge clk); #1;
        rst = 1'b1;
        req_valid = '0;
        @(posedge clk); #1;
        rst = 1'b0;
        model_last = 3;
        core_done = 1'b1;
        core_y = 32'h5555_AAAA;
        @(posedge clk); #1;
        core_done = 1'b0;
        chk("rstw_valid", {31'd0, out_valid}, 32'd0);
        chk("rstw_busy", {31'd0, busy}, 32'd0);
        @(posedge clk); #1;
        chk("rstw_valid2", {31'd0, out_valid}, 32'd0);
        txn(4'b1111, 2, 1, $urandom);

`ifdef FIR_SCHED_TIMEOUT_EN
        // Silent core: timeout after TO wait cycles, late core_done ignored
        start_txn(4'($urandom_range(1, 15)), g);
        n = 0;
        while (!out_valid && n < 4 * TO) begin
            @(posedge clk); #1;
            n++;
        end
        chk("to_valid", {31'd0, out_valid}, 32'd1);
        chk("to_cycles", n, TO + 1);
        chk("to_err", {31'd0, out_err}, 32'd1);
        chk("to_data", out_data, 32'd0);
        chk("to_chan", {30'd0, out_chan}, g);
        core_done = 1'b1;
        core_y = 32'hCAFE_F00D;
        @(posedge clk); #1;
        core_done = 1'b0;
        chk("to_late_data", out_data, 32'd0);
        chk("to_late_err", {31'd0, out_err}, 32'd1);
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        req_valid = '0;
        chk("to_idle", {31'd0, busy}, 32'd0);
        txn(4'b1111, 1, 0, $urandom);
`else
        n = 0;
        g = 0;
`endif

        // Randomized traffic
        for (int i = 0; i < 25; i++) begin
            txn(4'($urandom_range(1, 15)), $urandom_range(1, 6), $urandom_range(0, 3), $urandom);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/fir_channel_scheduler.md
FIR_CHANNEL_SCHEDULER -- requirements
Module: fir_channel_scheduler

Interface
REQ-001 SHALL have parameter NUM_CH, default 4: number of requesting channels, fixed at 4 in this revision.
REQ-002 SHALL have parameter DW, default 32: sample and result width.
REQ-003 SHALL have parameter TIMEOUT, default 63: maximum WAIT cycles before abort; used only with FIR_SCHED_TIMEOUT_EN.
REQ-004 SHALL have port clk, input, 1: clock; all logic on its rising edge.
REQ-005 SHALL have port rst, input, 1: synchronous, active-high reset.
REQ-006 SHALL have port req_valid, input, NUM_CH: per-channel sample valid.
REQ-007 SHALL have port req_data, input, NUM_CH*DW: channel k sample in bits [k*DW +: DW].
REQ-008 SHALL have port req_ready, output, NUM_CH: one-hot accept pulse to the granted channel.
REQ-009 SHALL have port core_start, output, 1: one-cycle start pulse to the shared FIR core.
REQ-010 SHALL have port core_x, output, DW: sample driven to the core, held stable from core_start until core_done.
REQ-011 SHALL have port core_done, input, 1: core result strobe.
REQ-012 SHALL have port core_y, input, DW: core result, valid with core_done.
REQ-013 SHALL have port out_valid, output, 1: result available.
REQ-014 SHALL have port out_ready, input, 1: downstream accepts the result.
REQ-015 SHALL have port out_data, output, DW: filtered result.
REQ-016 SHALL have port out_chan, output, 2: channel index of out_data.
REQ-017 SHALL have port out_err, output, 1: result aborted by timeout.
REQ-018 SHALL have port busy, output, 1: high in every state except IDLE.

Function
REQ-019 SHALL implement the states IDLE, ISSUE, WAIT and OUT.
REQ-020 In IDLE with any req_valid high, SHALL grant one channel round-robin, starting from channel (last_grant+1) mod 4.
REQ-021 On a grant, SHALL pulse req_ready[k] for that cycle, latch req_data[k] into core_x, latch k, and go to ISSUE.
REQ-022 In ISSUE, SHALL assert core_start for exactly one cycle and go to WAIT.
REQ-023 In WAIT, SHALL sample core_done only in that state, capture core_y into out_data, and go to OUT.
REQ-024 A core_done seen in IDLE, ISSUE or OUT SHALL be ignored.
REQ-025 In OUT, SHALL hold out_valid, out_data, out_chan and out_err stable until out_valid && out_ready.
REQ-026 On the OUT handshake, SHALL return to IDLE; the next grant occurs no earlier than the following cycle.
REQ-027 Minimum latency SHALL be: grant at cycle 0, core_start at cycle 1, out_valid the cycle after core_done.
REQ-028 SHALL update last_grant only on a grant; channels deasserting req_valid SHALL be skipped without stalling.
REQ-029 With a single requester, that channel SHALL be re-granted on every round.
REQ-030 With all four requesting continuously, grants SHALL follow the order 0,1,2,3,0,...

Reset
REQ-031 rst SHALL force IDLE and last_grant=3, so channel 0 has first priority.
REQ-032 rst SHALL force req_ready=0, core_start=0, core_x=0, out_valid=0, out_data=0, out_chan=0, out_err=0 and busy=0.
REQ-033 rst asserted mid-operation SHALL abandon the transaction; no result SHALL be emitted for it.

Configuration
REQ-034 With FIR_SCHED_TIMEOUT_EN defined, a counter SHALL count WAIT cycles.
REQ-035 If TIMEOUT cycles pass without core_done, SHALL go to OUT with out_data=0, out_err=1 and out_chan set to the granted channel.
REQ-036 A core_done arriving late, after a timeout, SHALL be ignored.
REQ-037 Without FIR_SCHED_TIMEOUT_EN, WAIT SHALL be unbounded and out_err SHALL be tied to 0.

Verification
REQ-038 After reset, only ch2 valid with data 0x00000005, core returns 0x0000000A three cycles after start -> req_ready=4'b0100, then core_start, then out_valid with out_data=0x0000000A and out_chan=2.
REQ-039 All channels valid continuously, out_ready tied high -> grant order 0,1,2,3,0,1 over six transactions.
REQ-040 out_ready held low 5 cycles in OUT -> out_valid, out_data and out_chan stable, no new req_ready, busy=1 throughout.
REQ-041 rst pulsed during WAIT, then core_done arrives -> no out_valid; next grant goes to ch0.
REQ-042 With FIR_SCHED_TIMEOUT_EN and TIMEOUT=63, core silent -> out_valid with out_err=1 and out_data=0; a later core_done is ignored.
REQ-043 core_done pulsed while IDLE with no requests -> no out_valid, state stays IDLE.
